// File: rtl/hevc_fdct_2d.sv
// hevc_fdct_2d -- forward 2-D HEVC integer DCT of one N x N residual block.
//
// One shared 16x8 multiplier and a 32-bit accumulator walk the row pass
// T = X * C^T and then the column pass Y = C * T. Each output element costs
// N MAC cycles plus one write cycle, so a block takes 2*N^2*(N+1) cycles.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (aborts a running block)
//   start  request, sampled only while idle
//   x      residual block x[row][col], signed 16-bit, captured on accept
//   busy   high from accept until done
//   y      coefficient block y[k][col], signed 16-bit, held between blocks
//   done   one-cycle completion pulse
//   sat    (FDCT_SAT_STATUS_EN only) sticky flag: some write clipped
//
// Optional feature macro: FDCT_SAT_STATUS_EN adds the sat status port.

module hevc_fdct_2d #(
   parameter int N         = 4,
   parameter int BIT_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [N-1:0][N-1:0][15:0] x,
   output logic                      busy,
   output logic [N-1:0][N-1:0][15:0] y,
   output logic                      done
`ifdef FDCT_SAT_STATUS_EN
   ,
   output logic                      sat
`endif
);

   localparam int LOGN    = $clog2(N);
   localparam int SHIFT_1 = LOGN + BIT_DEPTH - 9;
   localparam int SHIFT_2 = LOGN + 6;
   localparam logic signed [31:0] RND_1 = 32'sd1 <<< (SHIFT_1 - 1);
   localparam logic signed [31:0] RND_2 = 32'sd1 <<< (SHIFT_2 - 1);
   localparam logic [LOGN-1:0]    LAST  = LOGN'(N - 1);

   typedef enum logic [2:0] {IDLE, ROW_MAC, ROW_WR, COL_MAC, COL_WR} state_t;

   // HEVC_DCTn_ROM entry C[k][n]. Every N-point matrix is a row subset of
   // the 32-point one: C_N[k][n] = C_32[k*32/N][n]. The 32-point entry is
   // 64*sqrt(2)*cos((2n+1)*k*pi/64) rounded per the standard, so it is
   // folded by symmetry onto one magnitude table indexed by the angle.
   function automatic logic signed [7:0] dct_coef(input int k, input int n);
      int m;
      int v;
      bit neg;
      if (k == 0) return 8'sd64;
      m = ((2*n + 1) * k * (32 / N)) % 128;
      if (m > 64) m = 128 - m;
      neg = (m > 32);
      if (neg) m = 64 - m;
      case (m)
         1: v = 90;   2: v = 90;   3: v = 90;   4: v = 89;
         5: v = 88;   6: v = 87;   7: v = 85;   8: v = 83;
         9: v = 82;  10: v = 80;  11: v = 78;  12: v = 75;
        13: v = 73;  14: v = 70;  15: v = 67;  16: v = 64;
        17: v = 61;  18: v = 57;  19: v = 54;  20: v = 50;
        21: v = 46;  22: v = 43;  23: v = 38;  24: v = 36;
        25: v = 31;  26: v = 25;  27: v = 22;  28: v = 18;
        29: v = 13;  30: v = 9;   31: v = 4;
         default: v = 0;
      endcase
      return neg ? 8'(-v) : 8'(v);
   endfunction

   logic signed [7:0] rom [N][N];
   for (genvar gk = 0; gk < N; gk++) begin : g_rom_k
      for (genvar gn = 0; gn < N; gn++) begin : g_rom_n
         assign rom[gk][gn] = dct_coef(gk, gn);
      end
   end

   state_t state, state_nxt;

   // Row pass: cnt_a = r, cnt_b = k. Column pass: cnt_a = k, cnt_b = c.
   // cnt_n is the MAC index (n in the row pass, i in the column pass).
   logic [LOGN-1:0]   cnt_a, cnt_b, cnt_n;
   logic signed [15:0] xbuf [N][N];
   logic signed [15:0] tbuf [N][N];
   logic signed [31:0] acc;

   logic accept, mac_en, wr_en, row_ph, last_mac, last_elem;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = ROW_MAC;
         ROW_MAC: if (last_mac)  state_nxt = ROW_WR;
         ROW_WR:  state_nxt = last_elem ? COL_MAC : ROW_MAC;
         COL_MAC: if (last_mac)  state_nxt = COL_WR;
         COL_WR:  state_nxt = last_elem ? IDLE : COL_MAC;
         default: state_nxt = IDLE;
      endcase
   end

   // Control decode
   always_comb begin
      accept    = (state == IDLE) && start;
      mac_en    = (state == ROW_MAC) || (state == COL_MAC);
      wr_en     = (state == ROW_WR)  || (state == COL_WR);
      row_ph    = (state == ROW_MAC) || (state == ROW_WR);
      last_mac  = (cnt_n == LAST);
      last_elem = (cnt_a == LAST) && (cnt_b == LAST);
   end

   // Operand select and product
   logic signed [7:0]  coef_sel;
   logic signed [15:0] dat_sel;
   logic signed [23:0] prod;

   always_comb begin
      coef_sel = row_ph ? rom[cnt_b][cnt_n]  : rom[cnt_a][cnt_n];
      dat_sel  = row_ph ? xbuf[cnt_a][cnt_n] : tbuf[cnt_n][cnt_b];
      prod     = dat_sel * coef_sel;
   end

   // Round, floor-shift and saturate the finished sum
   logic signed [31:0] rsum, rshift;
   logic signed [15:0] wr_val;

   always_comb begin
      rsum   = acc + (row_ph ? RND_1 : RND_2);
      rshift = row_ph ? (rsum >>> SHIFT_1) : (rsum >>> SHIFT_2);
      if (rshift > 32767)       wr_val = 16'sh7fff;
      else if (rshift < -32768) wr_val = 16'sh8000;
      else                      wr_val = rshift[15:0];
   end

`ifdef FDCT_SAT_STATUS_EN
   logic wr_clip;
   assign wr_clip = (rshift > 32767) || (rshift < -32768);
`endif

   // Block buffers carry no reset: they are always rewritten before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               xbuf[r][c] <= $signed(x[r][c]);
      end
      if (wr_en && row_ph) tbuf[cnt_a][cnt_b] <= wr_val;
   end

   // Datapath, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         y     <= '0;
         acc   <= '0;
         cnt_a <= '0;
         cnt_b <= '0;
         cnt_n <= '0;
`ifdef FDCT_SAT_STATUS_EN
         sat   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            busy  <= 1'b1;
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_n <= '0;
`ifdef FDCT_SAT_STATUS_EN
            sat   <= 1'b0;
`endif
         end
         if (mac_en) begin
            // first term loads so no separate clear cycle is needed
            acc   <= (cnt_n == '0) ? 32'(prod) : acc + 32'(prod);
            cnt_n <= cnt_n + 1'b1;
         end
         if (wr_en) begin
            if (!row_ph) y[cnt_a][cnt_b] <= wr_val;
            cnt_b <= cnt_b + 1'b1;
            if (cnt_b == LAST) cnt_a <= cnt_a + 1'b1;
            if (!row_ph && last_elem) begin
               done <= 1'b1;
               busy <= 1'b0;
            end
`ifdef FDCT_SAT_STATUS_EN
            if (wr_clip) sat <= 1'b1;
`endif
         end
      end
   end

endmodule
